// File: rtl/regfile_pkg.sv
// regfile_pkg: FSM state type, default sizes and a flattened-bus field helper for regfile_mp.
// Latency: none (declarations only).
// Backpressure: none.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Widest flattened bus / single field the helper handles (4 read ports x 64 bits).
    localparam int MAX_BUS_W   = 256;
    localparam int MAX_FIELD_W = 64;

    // Field k of width w from a flattened bus, zero-extended to MAX_FIELD_W bits.
    function automatic logic [MAX_FIELD_W-1:0] get_field(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   k,
        input int                   w
    );
        logic [MAX_FIELD_W-1:0] mask;
        mask = (w >= MAX_FIELD_W) ? '1 : ((MAX_FIELD_W'(1) << w) - MAX_FIELD_W'(1));
        return MAX_FIELD_W'(bus >> (k * w)) & mask;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits with issue-over-retire priority and per-read-port lookup.
// Latency: set/clear visible one cycle after the edge; lookup is combinational.
// Backpressure: none; the caller gates set/clear while the register file is busy clearing.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NREGS  = NREGS_DEF,
    parameter int  NUM_RD = 2,
    parameter int  NUM_WR = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 set_en_i,
    input  logic [AW-1:0]        set_addr_i,
    input  logic [NUM_WR-1:0]    clr_en_i,
    input  logic [NUM_WR*AW-1:0] clr_addr_i,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]    rd_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy vector: flush beats everything, a new issue beats a retiring write.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (clr_en_i[w]) begin
                    busy_d[AW'(get_field(MAX_BUS_W'(clr_addr_i), w, AW))] = 1'b0;
                end
            end
            if (set_en_i) begin
                busy_d[set_addr_i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Busy-bit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Raw busy lookup per read port (register 0 is never busy).
    always_comb begin
        rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy_o[k] = busy_q[AW'(get_field(MAX_BUS_W'(rd_addr_i), k, AW))];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, x0 hardwired, busy scoreboard, bulk clear; REGFILE_BYPASS_EN adds same-cycle forwarding.
// Latency: combinational reads; writes visible next cycle (same cycle with bypass); clear takes NREGS-1 cycles.
// Backpressure: ready_po low during clear, when writes/issues/clear requests are dropped and reads return 0.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN   = XLEN_DEF,
    parameter int  NREGS  = NREGS_DEF,
    parameter int  NUM_RD = 2,
    parameter int  NUM_WR = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr_pi,
    output logic [NUM_RD*XLEN-1:0] rd_data_po,
    output logic [NUM_RD-1:0]      rd_busy_po,
    input  logic [NUM_WR-1:0]      wr_en_pi,
    input  logic [NUM_WR*AW-1:0]   wr_addr_pi,
    input  logic [NUM_WR*XLEN-1:0] wr_data_pi,
    input  logic                   issue_en_pi,
    input  logic [AW-1:0]          issue_addr_pi,
    input  logic                   clear_req_pi,
    output logic                   ready_po,
    output logic                   clear_done_po
);

    rf_state_e        state_q;
    rf_state_e        state_d;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    idx_d;
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [AW-1:0]    wr_addr [NUM_WR];
    logic [XLEN-1:0]  wr_data [NUM_WR];
    logic [NUM_WR-1:0] wr_act;
    logic [NUM_RD-1:0] sb_busy;
    logic             idle;

    assign idle     = (state_q == IDLE);
    assign ready_po = idle;

    // Unpack write ports; a write is live only while idle and never to register 0.
    always_comb begin
        wr_addr = '{default: '0};
        wr_data = '{default: '0};
        wr_act  = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_addr[w] = AW'(get_field(MAX_BUS_W'(wr_addr_pi), w, AW));
            wr_data[w] = XLEN'(get_field(MAX_BUS_W'(wr_data_pi), w, XLEN));
            wr_act[w]  = idle && wr_en_pi[w] && (wr_addr[w] != '0);
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (idle && clear_req_pi),
        .set_en_i   (idle && issue_en_pi),
        .set_addr_i (issue_addr_pi),
        .clr_en_i   (wr_act),
        .clr_addr_i (wr_addr_pi),
        .rd_addr_i  (rd_addr_pi),
        .rd_busy_o  (sb_busy)
    );

    // Clear FSM next state: sweep index 1..NREGS-1, done pulses on the last register.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        clear_done_po = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req_pi) begin
                    state_d = CLEAR;
                    idx_d   = AW'(1);
                end
            end
            CLEAR: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(NREGS - 1)) begin
                    state_d       = IDLE;
                    clear_done_po = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Data array: clear sweep or port writes; loop order lets port 1 win a same-address conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (!idle) begin
            regs_q[idx_q] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_act[w]) begin
                    regs_q[wr_addr[w]] <= wr_data[w];
                end
            end
        end
    end

    // Read ports: stored value (or forwarded write), zeroed for x0 and during clear.
    always_comb begin : rd_mux
        logic [AW-1:0]   raddr;
        logic [XLEN-1:0] rdat;
        logic            rbusy;
        raddr      = '0;
        rdat       = '0;
        rbusy      = 1'b0;
        rd_data_po = '0;
        rd_busy_po = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            raddr = AW'(get_field(MAX_BUS_W'(rd_addr_pi), k, AW));
            rdat  = regs_q[raddr];
            rbusy = sb_busy[k];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_act[w] && (wr_addr[w] == raddr)) begin
                    rdat  = wr_data[w];
                    rbusy = 1'b0;
                end
            end
`else
`endif
            if (!idle || (raddr == '0)) begin
                rdat  = '0;
                rbusy = 1'b0;
            end
            rd_data_po[k*XLEN +: XLEN] = rdat;
            rd_busy_po[k]              = rbusy;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp (default 32x32, 2R/2W) and a 16x64, 4R/1W instance.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_regfile_mp;

    localparam int AW  = 5;
    localparam int XL  = 32;
    localparam int BAW = 4;
    localparam int BXL = 64;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2*AW-1:0] a_rd_addr;
    logic [2*XL-1:0] a_rd_data;
    logic [1:0]      a_rd_busy;
    logic [1:0]      a_wr_en;
    logic [2*AW-1:0] a_wr_addr;
    logic [2*XL-1:0] a_wr_data;
    logic            a_issue_en;
    logic [AW-1:0]   a_issue_addr;
    logic            a_clear_req;
    logic            a_ready;
    logic            a_done;

    logic [4*BAW-1:0] b_rd_addr;
    logic [4*BXL-1:0] b_rd_data;
    logic [3:0]       b_rd_busy;
    logic [0:0]       b_wr_en;
    logic [BAW-1:0]   b_wr_addr;
    logic [BXL-1:0]   b_wr_data;
    logic             b_issue_en;
    logic [BAW-1:0]   b_issue_addr;
    logic             b_clear_req;
    logic             b_ready;
    logic             b_done;

    regfile_mp u_dut (
        .clk           (clk),
        .reset         (reset),
        .rd_addr_pi    (a_rd_addr),
        .rd_data_po    (a_rd_data),
        .rd_busy_po    (a_rd_busy),
        .wr_en_pi      (a_wr_en),
        .wr_addr_pi    (a_wr_addr),
        .wr_data_pi    (a_wr_data),
        .issue_en_pi   (a_issue_en),
        .issue_addr_pi (a_issue_addr),
        .clear_req_pi  (a_clear_req),
        .ready_po      (a_ready),
        .clear_done_po (a_done)
    );

    regfile_mp #(
        .XLEN   (BXL),
        .NREGS  (16),
        .NUM_RD (4),
        .NUM_WR (1)
    ) u_dut_wide (
        .clk           (clk),
        .reset         (reset),
        .rd_addr_pi    (b_rd_addr),
        .rd_data_po    (b_rd_data),
        .rd_busy_po    (b_rd_busy),
        .wr_en_pi      (b_wr_en),
        .wr_addr_pi    (b_wr_addr),
        .wr_data_pi    (b_wr_data),
        .issue_en_pi   (b_issue_en),
        .issue_addr_pi (b_issue_addr),
        .clear_req_pi  (b_clear_req),
        .ready_po      (b_ready),
        .clear_done_po (b_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic a_idle();
        a_wr_en     = '0;
        a_issue_en  = 1'b0;
        a_clear_req = 1'b0;
    endtask

    task automatic a_write(input int p, input logic [AW-1:0] ad, input logic [XL-1:0] d);
        a_wr_en[p]            = 1'b1;
        a_wr_addr[p*AW +: AW] = ad;
        a_wr_data[p*XL +: XL] = d;
    endtask

    task automatic a_raddr(input int k, input logic [AW-1:0] ad);
        a_rd_addr[k*AW +: AW] = ad;
    endtask

    function automatic logic [63:0] a_rd(input int k);
        return 64'(a_rd_data[k*XL +: XL]);
    endfunction

    int cyc;
    int dones;
    int not_ready;

    initial begin
        reset        = 1'b1;
        a_rd_addr    = '0;
        a_wr_addr    = '0;
        a_wr_data    = '0;
        a_issue_addr = '0;
        a_idle();
        b_rd_addr    = '0;
        b_wr_en      = '0;
        b_wr_addr    = '0;
        b_wr_data    = '0;
        b_issue_en   = 1'b0;
        b_issue_addr = '0;
        b_clear_req  = 1'b0;
        step();
        step();
        reset = 1'b0;
        a_raddr(0, 5'd5);
        a_raddr(1, 5'd31);
        settle();
        check("rst_ready", 64'(a_ready), 64'd1);
        check("rst_done", 64'(a_done), 64'd0);
        check("rst_rd0", a_rd(0), 64'd0);
        check("rst_rd1", a_rd(1), 64'd0);
        check("rst_busy", 64'(a_rd_busy), 64'd0);

        // Basic write then read.
        a_write(0, 5'd5, 32'hDEADBEEF);
        settle();
        check("wr5_same_cycle", a_rd(0), BYP ? 64'hDEADBEEF : 64'd0);
        step();
        a_idle();
        settle();
        check("wr5_next_cycle", a_rd(0), 64'hDEADBEEF);

        // Writes to x0 are dropped.
        a_write(0, 5'd0, 32'h1234);
        a_raddr(0, 5'd0);
        settle();
        check("x0_same_cycle", a_rd(0), 64'd0);
        step();
        a_idle();
        settle();
        check("x0_after", a_rd(0), 64'd0);

        // Dual-write conflict on x7, old value 0x33.
        a_write(0, 5'd7, 32'h33);
        step();
        a_idle();
        a_write(0, 5'd7, 32'h11);
        a_write(1, 5'd7, 32'h22);
        a_raddr(1, 5'd7);
        settle();
        check("x7_conflict_same", a_rd(1), BYP ? 64'h22 : 64'h33);
        step();
        a_idle();
        settle();
        check("x7_conflict_after", a_rd(1), 64'h22);

        // Scoreboard on x9.
        a_issue_en   = 1'b1;
        a_issue_addr = 5'd9;
        a_raddr(0, 5'd9);
        settle();
        check("busy9_before_edge", 64'(a_rd_busy[0]), 64'd0);
        step();
        a_idle();
        settle();
        check("busy9_set", 64'(a_rd_busy[0]), 64'd1);
        a_write(1, 5'd9, 32'h99);
        settle();
        check("busy9_write_same", 64'(a_rd_busy[0]), BYP ? 64'd0 : 64'd1);
        step();
        a_idle();
        settle();
        check("busy9_cleared", 64'(a_rd_busy[0]), 64'd0);
        check("x9_data", a_rd(0), 64'h99);
        a_write(0, 5'd9, 32'h98);
        a_issue_en   = 1'b1;
        a_issue_addr = 5'd9;
        step();
        a_idle();
        settle();
        check("busy9_set_wins", 64'(a_rd_busy[0]), 64'd1);
        a_issue_en   = 1'b1;
        a_issue_addr = 5'd0;
        a_raddr(1, 5'd0);
        step();
        a_idle();
        settle();
        check("busy0_ignored", 64'(a_rd_busy[1]), 64'd0);

        // Fill x1..x31, mark x3 busy, then run a full clear.
        for (int i = 1; i < 32; i++) begin
            a_write(0, AW'(i), XL'(32'h0101_0101 * i));
            step();
        end
        a_idle();
        a_issue_en   = 1'b1;
        a_issue_addr = 5'd3;
        step();
        a_idle();
        a_raddr(0, 5'd3);
        a_raddr(1, 5'd31);
        settle();
        check("busy3_pre_clear", 64'(a_rd_busy[0]), 64'd1);
        check("x31_pre_clear", a_rd(1), 64'h1F1F1F1F);
        a_clear_req = 1'b1;
        step();
        a_clear_req = 1'b0;
        cyc   = 0;
        dones = 0;
        while (a_ready == 1'b0 && cyc < 100) begin
            a_idle();
            if (a_done) dones++;
            if (cyc == 5) begin
                a_write(0, 5'd2, 32'hFFFF);
                a_issue_en   = 1'b1;
                a_issue_addr = 5'd4;
                a_raddr(0, 5'd20);
                settle();
                check("clear_rd_zero", a_rd(0), 64'd0);
            end
            cyc++;
            step();
        end
        a_idle();
        settle();
        check("clear_not_ready_cycles", 64'(cyc), 64'd31);
        check("clear_done_pulses", 64'(dones), 64'd1);
        check("clear_done_low_after", 64'(a_done), 64'd0);
        for (int i = 0; i < 32; i += 2) begin
            a_raddr(0, AW'(i));
            a_raddr(1, AW'(i + 1));
            settle();
            check($sformatf("cleared_x%0d", i), a_rd(0), 64'd0);
            check($sformatf("cleared_x%0d", i + 1), a_rd(1), 64'd0);
        end
        a_raddr(0, 5'd3);
        a_raddr(1, 5'd9);
        settle();
        check("busy3_after_clear", 64'(a_rd_busy[0]), 64'd0);
        check("busy9_after_clear", 64'(a_rd_busy[1]), 64'd0);
        a_raddr(0, 5'd4);
        settle();
        check("busy4_issue_lost", 64'(a_rd_busy[0]), 64'd0);

        // Reset ten cycles into a clear.
        a_write(0, 5'd20, 32'hABCD);
        step();
        a_idle();
        a_raddr(0, 5'd20);
        settle();
        check("x20_pre_reset", a_rd(0), 64'hABCD);
        a_clear_req = 1'b1;
        step();
        a_clear_req = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_done) dones++;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check("midclr_ready", 64'(a_ready), 64'd1);
        check("midclr_x20", a_rd(0), 64'd0);
        not_ready = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_done) dones++;
            if (!a_ready) not_ready++;
            step();
        end
        check("midclr_no_done", 64'(dones), 64'd0);
        check("midclr_stays_idle", 64'(not_ready), 64'd0);

        // Wide instance: four simultaneous 64-bit reads.
        b_wr_en = 1'b1;
        b_wr_addr = 4'd3;  b_wr_data = 64'h0123_4567_89AB_CDEF; step();
        b_wr_addr = 4'd7;  b_wr_data = 64'hFEDC_BA98_7654_3210; step();
        b_wr_addr = 4'd12; b_wr_data = 64'hDEAD_BEEF_CAFE_F00D; step();
        b_wr_addr = 4'd15; b_wr_data = 64'h8000_0000_0000_0001; step();
        b_wr_en = 1'b0;
        b_rd_addr = {4'd15, 4'd12, 4'd7, 4'd3};
        settle();
        check("wide_rd0", b_rd_data[0*BXL +: BXL], 64'h0123_4567_89AB_CDEF);
        check("wide_rd1", b_rd_data[1*BXL +: BXL], 64'hFEDC_BA98_7654_3210);
        check("wide_rd2", b_rd_data[2*BXL +: BXL], 64'hDEAD_BEEF_CAFE_F00D);
        check("wide_rd3", b_rd_data[3*BXL +: BXL], 64'h8000_0000_0000_0001);
        check("wide_ready", 64'(b_ready), 64'd1);
        check("wide_busy", 64'(b_rd_busy), 64'd0);
        check("wide_done", 64'(b_done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
